stage_id: RTL and testbench
===========================

Name: stage_id

Overview:
- Instruction-decode stage of the 5-stage pipelined MIPS CPU; the producer of every `id_*` signal the execute stage registers.
- Holds the IF/ID latch and the 32x32 register file with a writeback port.
- Decodes the supported MIPS subset into ALU op, operands, memory and writeback controls, branch type and target.
- Detects RAW hazards against EX/MEM (no forwarding) and stalls IF; redirects unconditional jumps itself.

Parameters:
- `ALU_OP_W`, 4, width of `id_op`; codes 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl.
- `RF_SRC_W`, 2, width of `id_rfSrc`; 0 = ALU result, 1 = memory read data.
- `BRANCH_W`, 3, width of `id_branchType`; 000 none, 001 beq (taken on zero), 010 bne.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: taken branch from EX; clears the IF/ID latch.
- `if_inst` in 32: fetched instruction.
- `if_pc4` in 32: PC+4 of `if_inst`.
- `ex_rfWE` in 1, `ex_rfDst` in 5: writeback of the instruction in EX.
- `mem_rfWE` in 1, `mem_rfDst` in 5: writeback of the instruction in MEM.
- `wb_rfWE` in 1, `wb_rfDst` in 5, `wb_rfData` in 32: register-file write port.
- `id_stall` out 1: freeze PC and IF.
- `id_jump` out 1, `id_jumpDst` out 32: jump redirect to IF.
- `id_op` out `ALU_OP_W`.
- `id_opa` out 32, `id_opb` out 32.
- `id_memWE` out 1, `id_memData` out 32.
- `id_rfWE` out 1, `id_rfDst` out 5, `id_rfSrc` out `RF_SRC_W`.
- `id_branchType` out `BRANCH_W`, `id_branchDst` out 32.

Behaviour:
- **Latch.** `inst_q`/`pc4_q` are 32-bit registers.
  - Priority: `rst` (async) > `flush` > stall > load.
  - `rst`/`flush`: both registers ← 0. Instruction 0 is a nop.
  - Stall: hold.
  - Unstalled jump in `inst_q`: `inst_q` ← 0 (squashes the wrong-path fetch), `pc4_q` ← `if_pc4`.
  - Otherwise: load `if_inst`/`if_pc4`.
- **Register file.**
  - Reset clears all 32 registers to 0.
  - On posedge, when `wb_rfWE` and `wb_rfDst` != 0, the register ← `wb_rfData`.
  - Reads are combinational; r0 always reads 0.
  - Same-cycle bypass: a read of `wb_rfDst` with `wb_rfWE` = 1 and `wb_rfDst` != 0 returns `wb_rfData`.
- **Outputs.** All `id_*` outputs are combinational from `inst_q`/`pc4_q` and the register file.
  - Latency: an instruction loaded at posedge N is decoded during cycle N+1 and registered by EX at posedge N+1.
  - During reset all outputs are 0.
- **Decode** (rs = [25:21], rt = [20:16], rd = [15:11], sh = [10:6], imm = [15:0]):
  - R-type, opcode 0x00:
    - funct 0x20 add / 0x22 sub / 0x24 and / 0x25 or: op 0/1/2/3, opa = R[rs], opb = R[rt], dst = rd.
    - funct 0x00 sll / 0x02 srl: op 4/5, opa = zext(sh), opb = R[rt], dst = rd.
    - Any other funct: bubble.
  - addi 0x08: op 0, opb = sext(imm), dst = rt.
  - andi 0x0C: op 2, opb = zext(imm), dst = rt.
  - ori 0x0D: op 3, opb = zext(imm), dst = rt.
  - lui 0x0F: op 0, opa = {imm, 16'h0}, opb = 0, dst = rt.
  - lw 0x23: op 0, opa = R[rs], opb = sext(imm), rfSrc = 1, dst = rt.
  - sw 0x2B: op 0, opa = R[rs], opb = sext(imm), memWE = 1, memData = R[rt], rfWE = 0.
  - beq 0x04 / bne 0x05: op 1, opa = R[rs], opb = R[rt], branchType 001/010, rfWE = 0.
  - Branch target: `id_branchDst` = `pc4_q` + (sext(imm) << 2), mod 2^32.
  - j 0x02: `id_jump` = 1, `id_jumpDst` = {`pc4_q`[31:28], inst[25:0], 2'b00}; all other controls bubble.
  - `id_rfWE` is forced 0 when dst = 0.
  - `id_memData` = 0 except on sw.
  - Unknown opcode: bubble.
- **Bubble.** All outputs 0: op add, `id_rfWE` = 0, `id_memWE` = 0, `id_branchType` = 000, `id_jump` = 0.
- **Hazard.**
  - Source registers used: rs by all except j, lui, sll, srl; rt by R-type, beq, bne, sw.
  - Hazard when a used source != 0 matches `ex_rfDst` with `ex_rfWE` = 1, or `mem_rfDst` with `mem_rfWE` = 1.
  - On hazard: `id_stall` = 1, outputs forced to bubble, latch holds.
  - A WB match is not a hazard (bypass covers it).
  - `id_stall` = hazard & ~`flush`.
  - A jump waits for no hazard; it has no sources.

Test Plan:
- Reset, then `if_inst` = 0x340100FF (ori r1,r0,0xFF) → next cycle `id_op` = 3, `id_opa` = 0, `id_opb` = 0x000000FF, `id_rfWE` = 1, `id_rfDst` = 1, `id_rfSrc` = 0.
- `wb_rfWE` = 1, `wb_rfDst` = 2, `wb_rfData` = 0x1234 in the same cycle as add r3,r2,r2 (0x00421820) in the latch → `id_opa` = `id_opb` = 0x1234, `id_rfDst` = 3; a following read of r2 also gives 0x1234.
- `ex_rfWE` = 1, `ex_rfDst` = 5, latch = 0x00A03020 (add r6,r5,r0) → `id_stall` = 1, `id_rfWE` = 0, `id_memWE` = 0, latch holds. Two cycles later, with EX/MEM clear → `id_rfDst` = 6, `id_stall` = 0.
- beq 0x1022FFFF with `pc4_q` = 0x100 → `id_branchType` = 001, `id_op` = 1, `id_branchDst` = 0x000000FC. Then `flush` = 1 together with a hazard → `id_stall` = 0, latch = 0, next-cycle outputs all 0.
- j 0x08000040 with `pc4_q` = 0x10000004 → `id_jump` = 1, `id_jumpDst` = 0x10000100, `id_rfWE` = 0; next cycle the latch holds 0 (nop).
- sw 0xAC450008 with R[2] = 0x40, R[5] = 0xDEAD → `id_op` = 0, `id_opa` = 0x40, `id_opb` = 8, `id_memWE` = 1, `id_memData` = 0xDEAD, `id_rfWE` = 0. Assert `rst` mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID latch, 32x32 register file with writeback
// bypass, MIPS-subset decoder, EX/MEM RAW hazard stall and jump redirect.
module stage_id #(
  parameter int ALU_OP_W = 4,
  parameter int RF_SRC_W = 2,
  parameter int BRANCH_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [31:0]         if_inst,
  input  logic [31:0]         if_pc4,
  input  logic                ex_rfWE,
  input  logic [4:0]          ex_rfDst,
  input  logic                mem_rfWE,
  input  logic [4:0]          mem_rfDst,
  input  logic                wb_rfWE,
  input  logic [4:0]          wb_rfDst,
  input  logic [31:0]         wb_rfData,
  output logic                id_stall,
  output logic                id_jump,
  output logic [31:0]         id_jumpDst,
  output logic [ALU_OP_W-1:0] id_op,
  output logic [31:0]         id_opa,
  output logic [31:0]         id_opb,
  output logic                id_memWE,
  output logic [31:0]         id_memData,
  output logic                id_rfWE,
  output logic [4:0]          id_rfDst,
  output logic [RF_SRC_W-1:0] id_rfSrc,
  output logic [BRANCH_W-1:0] id_branchType,
  output logic [31:0]         id_branchDst
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } br_e;

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z;
  logic [31:0] rs_val, rt_val;

  assign opcode = inst_q[31:26];
  assign rs     = inst_q[25:21];
  assign rt     = inst_q[20:16];
  assign rd     = inst_q[15:11];
  assign sh     = inst_q[10:6];
  assign funct  = inst_q[5:0];
  assign imm    = inst_q[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0000, imm};

  assign rs_val = (rs == 5'd0) ? '0 :
                  (wb_rfWE && wb_rfDst == rs) ? wb_rfData : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 :
                  (wb_rfWE && wb_rfDst == rt) ? wb_rfData : rf_q[rt];

  logic        use_rs, use_rt, writes, mem_we, src_mem, jump;
  alu_op_e     op;
  br_e         br;
  logic [31:0] opa, opb, mem_data, jump_dst, br_dst;
  logic [4:0]  dst;
  logic        hazard;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    writes   = 1'b0;
    mem_we   = 1'b0;
    src_mem  = 1'b0;
    jump     = 1'b0;
    op       = ALU_ADD;
    br       = BR_NONE;
    opa      = '0;
    opb      = '0;
    mem_data = '0;
    jump_dst = '0;
    br_dst   = '0;
    dst      = '0;
    case (opcode)
      // The all-zero word would otherwise decode as sll r0,r0,0; it is the canonical nop.
      OPC_RTYPE: if (inst_q != '0) begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            opa    = rs_val;
            opb    = rt_val;
            writes = 1'b1;
            dst    = rd;
            case (funct)
              FN_ADD:  op = ALU_ADD;
              FN_SUB:  op = ALU_SUB;
              FN_AND:  op = ALU_AND;
              default: op = ALU_OR;
            endcase
          end
          FN_SLL, FN_SRL: begin
            use_rt = 1'b1;
            op     = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            opa    = {27'd0, sh};
            opb    = rt_val;
            writes = 1'b1;
            dst    = rd;
          end
          default: ;
        endcase
      end
      OPC_ADDI, OPC_ANDI, OPC_ORI: begin
        use_rs = 1'b1;
        opa    = rs_val;
        writes = 1'b1;
        dst    = rt;
        case (opcode)
          OPC_ADDI: begin op = ALU_ADD; opb = imm_s; end
          OPC_ANDI: begin op = ALU_AND; opb = imm_z; end
          default:  begin op = ALU_OR;  opb = imm_z; end
        endcase
      end
      OPC_LUI: begin
        opa    = {imm, 16'h0000};
        writes = 1'b1;
        dst    = rt;
      end
      OPC_LW: begin
        use_rs  = 1'b1;
        opa     = rs_val;
        opb     = imm_s;
        src_mem = 1'b1;
        writes  = 1'b1;
        dst     = rt;
      end
      OPC_SW: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        opa      = rs_val;
        opb      = imm_s;
        mem_we   = 1'b1;
        mem_data = rt_val;
      end
      OPC_BEQ, OPC_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        op     = ALU_SUB;
        opa    = rs_val;
        opb    = rt_val;
        br     = (opcode == OPC_BEQ) ? BR_BEQ : BR_BNE;
        br_dst = pc4_q + {imm_s[29:0], 2'b00};
      end
      OPC_J: begin
        jump     = 1'b1;
        jump_dst = {pc4_q[31:28], inst_q[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  assign hazard =
    (use_rs && rs != 5'd0 &&
      ((ex_rfWE && ex_rfDst == rs) || (mem_rfWE && mem_rfDst == rs))) ||
    (use_rt && rt != 5'd0 &&
      ((ex_rfWE && ex_rfDst == rt) || (mem_rfWE && mem_rfDst == rt)));

  always_comb begin
    id_stall      = hazard & ~flush & ~rst;
    id_jump       = 1'b0;
    id_jumpDst    = '0;
    id_op         = '0;
    id_opa        = '0;
    id_opb        = '0;
    id_memWE      = 1'b0;
    id_memData    = '0;
    id_rfWE       = 1'b0;
    id_rfDst      = '0;
    id_rfSrc      = '0;
    id_branchType = '0;
    id_branchDst  = '0;
    if (!rst && !hazard) begin
      id_jump       = jump;
      id_jumpDst    = jump_dst;
      id_op         = ALU_OP_W'(op);
      id_opa        = opa;
      id_opb        = opb;
      id_memWE      = mem_we;
      id_memData    = mem_data;
      id_rfWE       = writes && (dst != 5'd0);
      id_rfDst      = dst;
      id_rfSrc      = RF_SRC_W'(src_mem);
      id_branchType = BRANCH_W'(br);
      id_branchDst  = br_dst;
    end
  end

  // A jump leaving the latch squashes the wrong-path fetch but keeps its PC+4.
  always_comb begin
    inst_d = if_inst;
    pc4_d  = if_pc4;
    if (flush) begin
      inst_d = '0;
      pc4_d  = '0;
    end else if (hazard) begin
      inst_d = inst_q;
      pc4_d  = pc4_q;
    end else if (opcode == OPC_J) begin
      inst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= '0;
      pc4_q  <= '0;
    end else begin
      inst_q <= inst_d;
      pc4_q  <= pc4_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_rfWE && wb_rfDst != 5'd0) begin
      rf_q[wb_rfDst] <= wb_rfData;
    end
  end

endmodule

// File: tb/tb_stage_id.sv
// Bench for stage_id: directed scenarios plus randomized traffic against an
// instruction-level model of the latch, register file and decoder.
module tb_stage_id;

  logic        clk, rst, flush;
  logic [31:0] if_inst, if_pc4;
  logic        ex_rfWE, mem_rfWE, wb_rfWE;
  logic [4:0]  ex_rfDst, mem_rfDst, wb_rfDst;
  logic [31:0] wb_rfData;
  logic        id_stall, id_jump, id_memWE, id_rfWE;
  logic [31:0] id_jumpDst, id_opa, id_opb, id_memData, id_branchDst;
  logic [3:0]  id_op;
  logic [4:0]  id_rfDst;
  logic [1:0]  id_rfSrc;
  logic [2:0]  id_branchType;

  stage_id #(.ALU_OP_W(4), .RF_SRC_W(2), .BRANCH_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_inst(if_inst), .if_pc4(if_pc4),
    .ex_rfWE(ex_rfWE), .ex_rfDst(ex_rfDst), .mem_rfWE(mem_rfWE), .mem_rfDst(mem_rfDst),
    .wb_rfWE(wb_rfWE), .wb_rfDst(wb_rfDst), .wb_rfData(wb_rfData),
    .id_stall(id_stall), .id_jump(id_jump), .id_jumpDst(id_jumpDst), .id_op(id_op),
    .id_opa(id_opa), .id_opb(id_opb), .id_memWE(id_memWE), .id_memData(id_memData),
    .id_rfWE(id_rfWE), .id_rfDst(id_rfDst), .id_rfSrc(id_rfSrc),
    .id_branchType(id_branchType), .id_branchDst(id_branchDst)
  );

  typedef struct packed {
    logic        stall;
    logic        jump;
    logic [31:0] jdst;
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        memWE;
    logic [31:0] memData;
    logic        rfWE;
    logic [4:0]  dst;
    logic [1:0]  src;
    logic [2:0]  bt;
    logic [31:0] bdst;
  } exp_t;

  logic [177:0] dut_vec;
  assign dut_vec = {id_stall, id_jump, id_jumpDst, id_op, id_opa, id_opb, id_memWE,
                    id_memData, id_rfWE, id_rfDst, id_rfSrc, id_branchType, id_branchDst};

  int checks = 0;
  int errors = 0;

  logic [31:0] m_inst, m_pc4;
  logic [31:0] m_rf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_rfWE && wb_rfDst == a) return wb_rfData;
    return m_rf[a];
  endfunction

  function automatic logic busy(input logic [4:0] a);
    return a != 5'd0 && ((ex_rfWE && ex_rfDst == a) || (mem_rfWE && mem_rfDst == a));
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [4:0] rs, rt, rd, d;
    logic [15:0] imm;
    logic [31:0] a, b, sx;
    logic urs, urt, wr;
    e = '0; urs = 0; urt = 0; wr = 0; d = 0;
    rs = m_inst[25:21]; rt = m_inst[20:16]; rd = m_inst[15:11]; imm = m_inst[15:0];
    a = rd_reg(rs); b = rd_reg(rt); sx = {{16{imm[15]}}, imm};
    if (m_inst == 32'd0) return e;
    case (m_inst[31:26])
      6'h00: case (m_inst[5:0])
        6'h20: begin e.op = 4'd0; e.opa = a; e.opb = b; urs = 1; urt = 1; wr = 1; d = rd; end
        6'h22: begin e.op = 4'd1; e.opa = a; e.opb = b; urs = 1; urt = 1; wr = 1; d = rd; end
        6'h24: begin e.op = 4'd2; e.opa = a; e.opb = b; urs = 1; urt = 1; wr = 1; d = rd; end
        6'h25: begin e.op = 4'd3; e.opa = a; e.opb = b; urs = 1; urt = 1; wr = 1; d = rd; end
        6'h00: begin e.op = 4'd4; e.opa = {27'd0, m_inst[10:6]}; e.opb = b; urt = 1; wr = 1; d = rd; end
        6'h02: begin e.op = 4'd5; e.opa = {27'd0, m_inst[10:6]}; e.opb = b; urt = 1; wr = 1; d = rd; end
        default: ;
      endcase
      6'h08: begin e.op = 4'd0; e.opa = a; e.opb = sx; urs = 1; wr = 1; d = rt; end
      6'h0C: begin e.op = 4'd2; e.opa = a; e.opb = {16'd0, imm}; urs = 1; wr = 1; d = rt; end
      6'h0D: begin e.op = 4'd3; e.opa = a; e.opb = {16'd0, imm}; urs = 1; wr = 1; d = rt; end
      6'h0F: begin e.opa = {imm, 16'd0}; wr = 1; d = rt; end
      6'h23: begin e.opa = a; e.opb = sx; e.src = 2'd1; urs = 1; wr = 1; d = rt; end
      6'h2B: begin e.opa = a; e.opb = sx; e.memWE = 1; e.memData = b; urs = 1; urt = 1; end
      6'h04, 6'h05: begin
        e.op = 4'd1; e.opa = a; e.opb = b; urs = 1; urt = 1;
        e.bt = (m_inst[31:26] == 6'h04) ? 3'b001 : 3'b010;
        e.bdst = m_pc4 + sx * 4;
      end
      6'h02: begin
        e.jump = 1;
        e.jdst = (m_pc4 & 32'hF000_0000) | ({6'd0, m_inst[25:0]} * 4);
      end
      default: ;
    endcase
    e.dst = d;
    e.rfWE = wr && d != 5'd0;
    if ((urs && busy(rs)) || (urt && busy(rt))) begin
      e = '0;
      e.stall = !flush;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_inst = 0; m_pc4 = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  task automatic idle();
    flush = 0; if_inst = 0; if_pc4 = 0;
    ex_rfWE = 0; ex_rfDst = 0; mem_rfWE = 0; mem_rfDst = 0;
    wb_rfWE = 0; wb_rfDst = 0; wb_rfData = 0;
  endtask

  // Clock edge with the model stepped from the pre-edge inputs; returns at edge+1.
  task automatic advance();
    exp_t e;
    logic [31:0] ni, np;
    e = model_out();
    ni = m_inst; np = m_pc4;
    if (flush) begin ni = 0; np = 0; end
    else if (!e.stall) begin
      ni = (m_inst[31:26] == 6'h02) ? 32'd0 : if_inst;
      np = if_pc4;
    end
    @(posedge clk);
    m_inst = ni; m_pc4 = np;
    if (wb_rfWE && wb_rfDst != 0) m_rf[wb_rfDst] = wb_rfData;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); model_reset();
    if_inst = 32'h00421820; wb_rfWE = 1; wb_rfDst = 2; wb_rfData = $urandom;
    #2;
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", dut_vec); end
    @(posedge clk); #1;
    if_inst = $urandom; ex_rfWE = 1; ex_rfDst = 1; #3;
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_held act=%h exp=0", dut_vec); end
    idle(); #2; rst = 0; #1;
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_release act=%h exp=0", dut_vec); end
    advance();
  endtask

  task automatic test_ori();
    if_inst = 32'h340100FF; if_pc4 = 32'h4; advance(); idle(); #4;
    checks++;
    if (id_op !== 4'd3 || id_opa !== 32'd0 || id_opb !== 32'hFF || id_rfWE !== 1'b1 ||
        id_rfDst !== 5'd1 || id_rfSrc !== 2'd0) begin
      errors++;
      $display("FAIL ori op=%0d opa=%h opb=%h we=%b dst=%0d src=%0d exp 3/0/ff/1/1/0",
               id_op, id_opa, id_opb, id_rfWE, id_rfDst, id_rfSrc);
    end
    advance();
  endtask

  task automatic test_bypass();
    if_inst = 32'h00421820; advance();
    idle(); if_inst = 32'h00401820; wb_rfWE = 1; wb_rfDst = 2; wb_rfData = 32'h1234; #4;
    checks++;
    if (id_opa !== 32'h1234 || id_opb !== 32'h1234 || id_rfDst !== 5'd3) begin
      errors++; $display("FAIL wb_bypass opa=%h opb=%h dst=%0d exp 1234/1234/3", id_opa, id_opb, id_rfDst);
    end
    advance(); idle(); #4;
    checks++;
    if (id_opa !== 32'h1234 || id_opb !== 32'h0) begin
      errors++; $display("FAIL rf_written opa=%h opb=%h exp 1234/0", id_opa, id_opb);
    end
    advance();
  endtask

  task automatic test_hazard();
    if_inst = 32'h00A03020; advance();
    idle(); if_inst = 32'h34070007; ex_rfWE = 1; ex_rfDst = 5; #4;
    checks++;
    if (id_stall !== 1'b1 || id_rfWE !== 1'b0 || id_memWE !== 1'b0) begin
      errors++; $display("FAIL ex_hazard stall=%b we=%b mwe=%b exp 1/0/0", id_stall, id_rfWE, id_memWE);
    end
    advance(); ex_rfWE = 0; mem_rfWE = 1; mem_rfDst = 5; #4;
    checks++;
    if (id_stall !== 1'b1 || id_rfWE !== 1'b0) begin
      errors++; $display("FAIL mem_hazard stall=%b we=%b exp 1/0", id_stall, id_rfWE);
    end
    advance(); mem_rfWE = 0; #4;
    checks++;
    if (id_stall !== 1'b0 || id_rfDst !== 5'd6 || id_rfWE !== 1'b1) begin
      errors++; $display("FAIL hazard_clear stall=%b dst=%0d we=%b exp 0/6/1", id_stall, id_rfDst, id_rfWE);
    end
    advance(); idle();
  endtask

  task automatic test_branch_flush();
    if_inst = 32'h1022FFFF; if_pc4 = 32'h100; advance();
    idle(); #4;
    checks++;
    if (id_branchType !== 3'b001 || id_op !== 4'd1 || id_branchDst !== 32'hFC) begin
      errors++; $display("FAIL beq bt=%b op=%0d dst=%h exp 001/1/fc", id_branchType, id_op, id_branchDst);
    end
    advance(); idle(); if_inst = 32'h1022FFFF; if_pc4 = 32'h200; advance();
    idle(); flush = 1; ex_rfWE = 1; ex_rfDst = 1; if_inst = 32'h34010001; if_pc4 = 32'h204; #4;
    checks++;
    if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall act=%b exp 0", id_stall); end
    advance(); idle(); #4;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL flush_clear act=%h exp=0", dut_vec); end
    advance();
  endtask

  task automatic test_jump();
    if_inst = 32'h08000040; if_pc4 = 32'h10000004; advance();
    idle(); if_inst = 32'h34080001; if_pc4 = 32'h10000008; #4;
    checks++;
    if (id_jump !== 1'b1 || id_jumpDst !== 32'h10000100 || id_rfWE !== 1'b0 || id_stall !== 1'b0) begin
      errors++; $display("FAIL jump j=%b dst=%h we=%b st=%b exp 1/10000100/0/0", id_jump, id_jumpDst, id_rfWE, id_stall);
    end
    advance(); idle(); #4;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL jump_squash act=%h exp=0", dut_vec); end
    advance();
  endtask

  task automatic test_sw_reset();
    wb_rfWE = 1; wb_rfDst = 2; wb_rfData = 32'h40; advance();
    wb_rfDst = 5; wb_rfData = 32'hDEAD; advance();
    idle(); if_inst = 32'hAC450008; advance();
    idle(); #4;
    checks++;
    if (id_op !== 4'd0 || id_opa !== 32'h40 || id_opb !== 32'h8 || id_memWE !== 1'b1 ||
        id_memData !== 32'hDEAD || id_rfWE !== 1'b0) begin
      errors++;
      $display("FAIL sw op=%0d opa=%h opb=%h mwe=%b md=%h we=%b exp 0/40/8/1/dead/0",
               id_op, id_opa, id_opb, id_memWE, id_memData, id_rfWE);
    end
    #1 rst = 1; #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL async_reset act=%h exp=0", dut_vec); end
    model_reset(); #1 rst = 0;
    if_inst = 32'h00453820; advance();
    idle(); #4;
    checks++;
    if (id_opa !== 32'd0 || id_opb !== 32'd0 || id_rfDst !== 5'd7) begin
      errors++; $display("FAIL rf_cleared opa=%h opb=%h dst=%0d exp 0/0/7", id_opa, id_opb, id_rfDst);
    end
    advance();
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 15))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4:  return {6'h00, 5'd0, rt, rd, imm[4:0], 6'h00};
      5:  return {6'h00, 5'd0, rt, rd, imm[4:0], 6'h02};
      6:  return {6'h08, rs, rt, imm};
      7:  return {6'h0C, rs, rt, imm};
      8:  return {6'h0D, rs, rt, imm};
      9:  return {6'h0F, 5'd0, rt, imm};
      10: return {6'h23, rs, rt, imm};
      11: return {6'h2B, rs, rt, imm};
      12: return {6'h04, rs, rt, imm};
      13: return {6'h05, rs, rt, imm};
      14: return {6'h02, 26'($urandom)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      if_inst = gen_inst(); if_pc4 = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      ex_rfWE = 1'($urandom); ex_rfDst = 5'($urandom_range(0, 7));
      mem_rfWE = 1'($urandom); mem_rfDst = 5'($urandom_range(0, 7));
      wb_rfWE = 1'($urandom); wb_rfDst = 5'($urandom_range(0, 7)); wb_rfData = $urandom;
      #4;
      e = model_out();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL random[%0d] inst=%h act=%h exp=%h", n, m_inst, dut_vec, e);
      end
      advance();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ori();
    test_bypass();
    test_hazard();
    test_branch_flush();
    test_jump();
    test_sw_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
